// File: rtl/aes_spi_responder_pkg.sv
// Shared definitions for the AES SPI responder: FSM state encoding,
// block/counter widths and the RX frame length helper.
package aes_spi_responder_pkg;

  localparam int unsigned BLOCK_BITS = 128;
  localparam int unsigned CNT_W      = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX    = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    MARK  = 3'd4,
    TX    = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Bits in one received frame: data block followed by an Nk-word key.
  function automatic int unsigned frame_bits(input int unsigned nk);
    return BLOCK_BITS + nk * 32;
  endfunction

endpackage

// File: rtl/aes_spi_responder_shift_reg.sv
// Generic MSB-first shift register with parallel load; used for both the
// receive frame and the transmit result.
module spi_shift_reg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // Parallel load wins over shift; shift moves toward the MSB, new bit at LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/aes_spi_responder.sv
// SPI slave endpoint for an AES core: receives data block + key on SDI,
// launches the core, and returns a marker bit followed by the 128-bit
// result on SDO. CS high aborts any frame in progress.
module aes_spi_responder
  import aes_spi_responder_pkg::*;
#(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CS,
  input  logic                  SDI,
  output logic                  SDO,
  output logic                  core_start,
  output logic [BLOCK_BITS-1:0] core_data,
  output logic [Nk*32-1:0]      core_key,
  input  logic                  core_done,
  input  logic [BLOCK_BITS-1:0] core_result,
  output logic                  busy
);

  localparam int unsigned FRAME_BITS = frame_bits(Nk);
  localparam int unsigned KEY_BITS   = Nk * 32;
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(BLOCK_BITS - 1);

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic                    sdo_d;
  logic                    rx_shift, tx_shift, tx_load, core_load;
  logic [FRAME_BITS-1:0]   rx_q, rx_frame;
  logic [BLOCK_BITS-1:0]   tx_q;

  spi_shift_reg #(.WIDTH(FRAME_BITS)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .shift_en (rx_shift),
    .load_en  (1'b0),
    .load_val ('0),
    .sin      (SDI),
    .q        (rx_q)
  );

  spi_shift_reg #(.WIDTH(BLOCK_BITS)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .shift_en (tx_shift),
    .load_en  (tx_load),
    .load_val (core_result),
    .sin      (1'b0),
    .q        (tx_q)
  );

  // The last frame bit is captured into core_data/core_key on the same edge
  // it is sampled, so the latch uses the shifted value rather than rx_q.
  assign rx_frame   = {rx_q[FRAME_BITS-2:0], SDI};
  assign core_start = (state == START);
  assign busy       = (state != IDLE);

  // Next-state, counter, shift control and registered-SDO value.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    sdo_d     = 1'b0;
    rx_shift  = 1'b0;
    tx_shift  = 1'b0;
    tx_load   = 1'b0;
    core_load = 1'b0;
    case (state)
      IDLE: begin
        if (!CS) begin
          rx_shift = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = RX;
        end
      end
      RX: begin
        if (CS) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rx_shift = 1'b1;
          cnt_d    = cnt + CNT_W'(1);
          if (cnt == RX_LAST) begin
            core_load = 1'b1;
            state_d   = START;
          end
        end
      end
      START: begin
        if (CS) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (CS) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (core_done) begin
          tx_load = 1'b1;
          sdo_d   = 1'b1;
          cnt_d   = '0;
          state_d = MARK;
        end
      end
      MARK: begin
        if (CS) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          sdo_d    = tx_q[BLOCK_BITS-1];
          tx_shift = 1'b1;
          cnt_d    = '0;
          state_d  = TX;
        end
      end
      TX: begin
        if (CS) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == TX_LAST) begin
          state_d = DONE;
        end else begin
          sdo_d    = tx_q[BLOCK_BITS-1];
          tx_shift = 1'b1;
          cnt_d    = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (CS) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, bit counter and registered SDO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      SDO   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      SDO   <= sdo_d;
    end
  end

  // Latched operands for the core; held across aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_data <= '0;
      core_key  <= '0;
    end else if (core_load) begin
      core_data <= rx_frame[FRAME_BITS-1 -: BLOCK_BITS];
      core_key  <= rx_frame[KEY_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_aes_spi_responder.sv
// Directed testbench for aes_spi_responder: one Nk=4 and one Nk=8 instance,
// each with a stub AES core answering a fixed result 12 cycles after start.
module tb_aes_spi_responder;

  localparam logic [127:0] DATA   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] DATA2  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RES128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RES256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         cs4, sdi4, sdo4, start4, done4, busy4;
  logic [127:0] data4, res4;
  logic [127:0] key4;
  logic         cs8, sdi8, sdo8, start8, done8, busy8;
  logic [127:0] data8, res8;
  logic [255:0] key8;

  int n_tests = 0;
  int n_fail  = 0;

  aes_spi_responder #(.Nk(4), .Nr(10)) dut4 (
    .clk(clk), .rst(rst), .CS(cs4), .SDI(sdi4), .SDO(sdo4),
    .core_start(start4), .core_data(data4), .core_key(key4),
    .core_done(done4), .core_result(res4), .busy(busy4)
  );

  aes_spi_responder #(.Nk(8), .Nr(14)) dut8 (
    .clk(clk), .rst(rst), .CS(cs8), .SDI(sdi8), .SDO(sdo8),
    .core_start(start8), .core_data(data8), .core_key(key8),
    .core_done(done8), .core_result(res8), .busy(busy8)
  );

  // Stub cores: done pulses a fixed number of cycles after start is seen.
  int unsigned scnt4, scnt8;
  int starts4 = 0;
  int starts8 = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) scnt4 <= 0;
    else if (start4) scnt4 <= 12;
    else if (scnt4 != 0) scnt4 <= scnt4 - 1;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) scnt8 <= 0;
    else if (start8) scnt8 <= 12;
    else if (scnt8 != 0) scnt8 <= scnt8 - 1;
  end
  assign done4 = (scnt4 == 1);
  assign done8 = (scnt8 == 1);
  always @(posedge clk) if (start4) starts4 <= starts4 + 1;
  always @(posedge clk) if (start8) starts8 <= starts8 + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bits(input bit sel8, input logic [383:0] f, input int n, input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      if (sel8) begin cs8 = 1'b0; sdi8 = f[n-1-i]; end
      else      begin cs4 = 1'b0; sdi4 = f[n-1-i]; end
    end
  endtask

  task automatic recv_result(input bit sel8, output logic [127:0] r, output bit got_marker,
                             output logic tail_sdo, output logic tail_busy);
    got_marker = 1'b0;
    r = '0;
    tail_sdo = 1'bx;
    tail_busy = 1'bx;
    for (int i = 0; i < 100 && !got_marker; i++) begin
      @(negedge clk);
      if ((sel8 ? sdo8 : sdo4) === 1'b1) got_marker = 1'b1;
    end
    if (got_marker) begin
      for (int i = 0; i < 128; i++) begin
        @(negedge clk);
        r = {r[126:0], (sel8 ? sdo8 : sdo4)};
      end
      @(negedge clk);
      tail_sdo  = sel8 ? sdo8 : sdo4;
      tail_busy = sel8 ? busy8 : busy4;
    end
  endtask

  task automatic deselect(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      cs4 = 1'b1;
      cs8 = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cs4 = 1'b1; cs8 = 1'b1; sdi4 = 1'b0; sdi8 = 1'b0;
    res4 = RES128; res8 = RES256;
    #12;
    n_tests++;
    if ({sdo4, start4, busy4} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl4: got %b expected 000", {sdo4, start4, busy4});
    end
    n_tests++;
    if ({data4, key4} !== 256'h0) begin
      n_fail++; $display("FAIL reset_regs4: got %h expected 0", {data4, key4});
    end
    n_tests++;
    if ({sdo8, start8, busy8} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl8: got %b expected 000", {sdo8, start8, busy8});
    end
    n_tests++;
    if ({data8, key8} !== 384'h0) begin
      n_fail++; $display("FAIL reset_regs8: got %h expected 0", {data8, key8});
    end
    @(negedge clk);
    rst = 1'b0;
    deselect(2);
  endtask

  task automatic test_nk4_nominal;
    logic [383:0] f;
    logic [127:0] r;
    bit got;
    logic tsdo, tbusy;
    int s0;
    s0 = starts4;
    f = '0;
    f[255:0] = {DATA, KEY128};
    drive_bits(1'b0, f, 256, 256);
    @(negedge clk);
    n_tests++;
    if (start4 !== 1'b1) begin
      n_fail++; $display("FAIL nk4_start: got %b expected 1", start4);
    end
    n_tests++;
    if (data4 !== DATA) begin
      n_fail++; $display("FAIL nk4_data: got %h expected %h", data4, DATA);
    end
    n_tests++;
    if (key4 !== KEY128) begin
      n_fail++; $display("FAIL nk4_key: got %h expected %h", key4, KEY128);
    end
    recv_result(1'b0, r, got, tsdo, tbusy);
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL nk4_marker: got none expected 1");
    end
    n_tests++;
    if (r !== RES128) begin
      n_fail++; $display("FAIL nk4_result: got %h expected %h", r, RES128);
    end
    n_tests++;
    if ({tsdo, tbusy} !== 2'b01) begin
      n_fail++; $display("FAIL nk4_done_state: got sdo/busy %b expected 01", {tsdo, tbusy});
    end
    n_tests++;
    if (starts4 - s0 !== 1) begin
      n_fail++; $display("FAIL nk4_start_count: got %0d expected 1", starts4 - s0);
    end
    deselect(2);
    n_tests++;
    if (busy4 !== 1'b0) begin
      n_fail++; $display("FAIL nk4_idle_after: got busy %b expected 0", busy4);
    end
  endtask

  task automatic test_nk8_frame;
    logic [383:0] f;
    logic [127:0] r;
    bit got;
    logic tsdo, tbusy;
    int s0;
    s0 = starts8;
    f = {DATA, KEY256};
    drive_bits(1'b1, f, 384, 384);
    n_tests++;
    if (start8 !== 1'b0) begin
      n_fail++; $display("FAIL nk8_start_early: got %b expected 0", start8);
    end
    @(negedge clk);
    n_tests++;
    if (start8 !== 1'b1) begin
      n_fail++; $display("FAIL nk8_start: got %b expected 1", start8);
    end
    n_tests++;
    if (key8 !== KEY256) begin
      n_fail++; $display("FAIL nk8_key: got %h expected %h", key8, KEY256);
    end
    n_tests++;
    if (data8 !== DATA) begin
      n_fail++; $display("FAIL nk8_data: got %h expected %h", data8, DATA);
    end
    @(negedge clk);
    n_tests++;
    if (start8 !== 1'b0) begin
      n_fail++; $display("FAIL nk8_start_width: got %b expected 0", start8);
    end
    recv_result(1'b1, r, got, tsdo, tbusy);
    n_tests++;
    if (!got || r !== RES256) begin
      n_fail++; $display("FAIL nk8_result: got %h (marker %0d) expected %h", r, got, RES256);
    end
    n_tests++;
    if (tsdo !== 1'b0 || starts8 - s0 !== 1) begin
      n_fail++; $display("FAIL nk8_tail: got sdo %b starts %0d expected 0 and 1", tsdo, starts8 - s0);
    end
    deselect(2);
  endtask

  task automatic test_abort_rx;
    logic [383:0] f;
    logic [127:0] r;
    bit got;
    logic tsdo, tbusy;
    int s0;
    s0 = starts4;
    f = '0;
    f[255:0] = {DATA2, KEY128};
    drive_bits(1'b0, f, 256, 100);
    @(negedge clk);
    cs4 = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy4, sdo4} !== 2'b00) begin
      n_fail++; $display("FAIL abort_rx_idle: got busy/sdo %b expected 00", {busy4, sdo4});
    end
    deselect(20);
    n_tests++;
    if (starts4 !== s0) begin
      n_fail++; $display("FAIL abort_rx_nostart: got %0d starts expected 0", starts4 - s0);
    end
    n_tests++;
    if (data4 !== DATA) begin
      n_fail++; $display("FAIL abort_rx_hold: got %h expected %h", data4, DATA);
    end
    drive_bits(1'b0, f, 256, 256);
    @(negedge clk);
    n_tests++;
    if (start4 !== 1'b1 || data4 !== DATA2) begin
      n_fail++; $display("FAIL abort_rx_next_frame: got start %b data %h expected 1 %h", start4, data4, DATA2);
    end
    recv_result(1'b0, r, got, tsdo, tbusy);
    n_tests++;
    if (!got || r !== RES128) begin
      n_fail++; $display("FAIL abort_rx_next_result: got %h (marker %0d) expected %h", r, got, RES128);
    end
    deselect(2);
  endtask

  task automatic test_abort_wait;
    logic [383:0] f;
    bit bad, saw_done;
    f = '0;
    f[255:0] = {DATA, KEY128};
    drive_bits(1'b0, f, 256, 256);
    @(negedge clk);
    @(negedge clk);
    cs4 = 1'b1;
    bad = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) saw_done = 1'b1;
      if (i > 0 && (sdo4 !== 1'b0 || busy4 !== 1'b0)) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL abort_wait_quiet: got sdo/busy activity expected none");
    end
    n_tests++;
    if (!saw_done) begin
      n_fail++; $display("FAIL abort_wait_stub: got no core_done expected one");
    end
    n_tests++;
    if (data4 !== DATA || key4 !== KEY128) begin
      n_fail++; $display("FAIL abort_wait_hold: got %h %h expected %h %h", data4, key4, DATA, KEY128);
    end
  endtask

  task automatic test_reset_mid_tx;
    logic [383:0] f;
    logic [127:0] r;
    bit got;
    logic tsdo, tbusy;
    f = '0;
    f[255:0] = {DATA, KEY128};
    drive_bits(1'b0, f, 256, 256);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (sdo4 === 1'b1) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL rst_tx_marker: got none expected 1");
    end
    for (int i = 0; i < 40; i++) @(negedge clk);
    #2;
    rst = 1'b1;
    cs4 = 1'b1;
    cs8 = 1'b1;
    #1;
    n_tests++;
    if ({sdo4, busy4} !== 2'b00) begin
      n_fail++; $display("FAIL rst_tx_async: got sdo/busy %b expected 00", {sdo4, busy4});
    end
    n_tests++;
    if (data4 !== '0) begin
      n_fail++; $display("FAIL rst_tx_data: got %h expected 0", data4);
    end
    #1;
    rst = 1'b0;
    deselect(2);
    drive_bits(1'b0, f, 256, 256);
    recv_result(1'b0, r, got, tsdo, tbusy);
    n_tests++;
    if (!got || r !== RES128 || data4 !== DATA) begin
      n_fail++; $display("FAIL rst_tx_recover: got %h data %h expected %h %h", r, data4, RES128, DATA);
    end
    deselect(2);
  endtask

  task automatic test_rearm;
    logic [383:0] f;
    logic [127:0] r;
    bit got, bad;
    logic tsdo, tbusy;
    int s0;
    s0 = starts4;
    f = '0;
    f[255:0] = {DATA, KEY128};
    drive_bits(1'b0, f, 256, 256);
    recv_result(1'b0, r, got, tsdo, tbusy);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cs4 = 1'b0;
      sdi4 = 1'($urandom_range(0, 1));
      if (busy4 !== 1'b1 || sdo4 !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL rearm_hold_done: got leave of DONE expected stay");
    end
    n_tests++;
    if (starts4 - s0 !== 1) begin
      n_fail++; $display("FAIL rearm_single_start: got %0d expected 1", starts4 - s0);
    end
    @(negedge clk);
    cs4 = 1'b1;
    f[255:0] = {DATA2, KEY128};
    drive_bits(1'b0, f, 256, 256);
    @(negedge clk);
    n_tests++;
    if (start4 !== 1'b1 || data4 !== DATA2) begin
      n_fail++; $display("FAIL rearm_new_frame: got start %b data %h expected 1 %h", start4, data4, DATA2);
    end
    recv_result(1'b0, r, got, tsdo, tbusy);
    n_tests++;
    if (!got || r !== RES128) begin
      n_fail++; $display("FAIL rearm_result: got %h (marker %0d) expected %h", r, got, RES128);
    end
    deselect(2);
  endtask

  initial begin
    test_reset;
    test_nk4_nominal;
    test_nk8_frame;
    test_abort_rx;
    test_abort_wait;
    test_reset_mid_tx;
    test_rearm;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_spi_responder.md
Name: aes_spi_responder

Overview:
- Slave-side SPI endpoint for the AES cipher/inverse-cipher cores; the responder for the AES SPI master.
- Serially receives a 128-bit data block followed by an Nk*32-bit key on SDI, launches the attached AES core with a start/done handshake, then serially returns the 128-bit result on SDO.
- One instance is placed per core (encrypt, decrypt); the master selects between them with per-instance chip select.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8); RX frame length = 128+Nk*32 bits.
- Nr, 10, round count; passed through only, no internal use.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset: asynchronous, active-high.
- CS  in  1  chip select, active-low; high = deselected/abort.
- SDI  in  1  serial data from master, one bit per clk, MSB first.
- SDO  out  1  serial data to master, registered.
- core_start  out  1  one-cycle launch pulse to AES core.
- core_data  out  128  latched data block.
- core_key  out  Nk*32  latched key.
- core_done  in  1  core result valid, one-cycle pulse or level.
- core_result  in  128  core output, sampled on core_done.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: SDO=0, core_start=0, core_data=0, core_key=0, busy=0, state=IDLE, bit counter=0, TX shift register=0.
- Internal 9-bit bit counter; RX shift register of width 128+Nk*32; 128-bit TX shift register.
- IDLE: SDO=0. On CS=0, sample SDI as bit 0 at that same posedge, set counter=1, go to RX.
- RX: while CS=0, shift SDI into the LSB of the RX register each cycle and increment the counter.
- RX completion: when counter reaches 128+Nk*32, i.e. the last bit is sampled on that edge:
  - load core_data from the upper 128 bits and core_key from the lower Nk*32 bits;
  - go to START.
- START: core_start=1 for exactly one cycle, then go to WAIT.
- WAIT: SDO=0. On core_done=1, capture core_result into the TX register and go to MARK. A core_done in the same cycle as core_start is ignored.
- MARK: SDO=1 for exactly one cycle as the start-of-result marker. Counter=0. Go to TX.
- TX: SDO = TX[127] each cycle, shift left, increment counter. After 128 bits (counter=127 on the last bit), go to DONE.
- DONE: SDO=0. Stay in DONE until CS=1, then go to IDLE. CS must be seen high before a new frame is accepted.
- Abort: CS=1 in any state other than IDLE or DONE forces IDLE next cycle with SDO=0 and counter cleared.
  - core_data and core_key hold their values.
  - An in-flight core result is discarded; a core_done arriving in IDLE is ignored.
- Asynchronous rst mid-frame returns everything to reset values immediately. No partial result is ever emitted.
- Latency: last RX bit → core_start is 1 cycle; core_done → marker is 1 cycle; marker → first result bit is 1 cycle.
- SDO changes only on posedge; the master samples it on negedge.

Decomposition:
- Shared package holds:
  - state encoding IDLE/RX/START/WAIT/MARK/TX/DONE (3 bits);
  - constants BLOCK_BITS=128 and CNT_W=9;
  - a frame-length function of Nk.
- One natural sub-module, spi_shift_reg:
  - parameterised width; serial in, serial out, parallel load;
  - instantiated for both RX and TX.
- FSM and counter stay in aes_spi_responder.

Test Plan:
- Nk=4 nominal frame:
  - Stimulus: data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f; stub core returns 69c4e0d86a7b0430d8cdb78070b4c55a after 12 cycles.
  - Required: core_data and core_key match exactly; one core_start pulse; SDO gives marker 1 then 128 bits equal to 69c4…c55a; then SDO=0.
- Nk=8 frame:
  - Stimulus: 384-bit frame; key 000102…1e1f; stub returns 8ea2b7ca516745bfeafc49904b496089.
  - Required: core_key equals all 256 bits; core_start asserts 1 cycle after bit 384.
- Abort in RX: CS raised after 100 bits → IDLE next cycle, no core_start. A following full frame works normally.
- Abort in WAIT: CS raised before core_done → core_done later ignored, SDO stays 0, busy=0.
- Reset mid-TX: async rst pulse at result bit 40 → SDO=0 and busy=0 without waiting for a clk edge; a full frame after reset is correct.
- Re-arm: CS held low after DONE → no second transaction. CS high for 1 cycle then low → new frame accepted.
